// File: rtl/rtgpu_arb_pkg.sv
// Shared types and sizing helpers for the round-robin burst arbiter.
package rtgpu_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width for a one-hot vector of n ports (never less than one bit)
  function automatic int calc_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/priority_arbiter.sv
// Fixed-priority one-hot arbiter: the lowest-indexed active request wins.
module priority_arbiter #(
  parameter int N = 16
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = req[i] & ~found;
      found    = found | req[i];
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one requester a locked burst of len+1 beats
// on a shared downstream port; the priority pointer rotates on burst completion.
module rr_burst_arbiter
  import rtgpu_arb_pkg::*;
#(
  parameter int NUM_PORTS = 16,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  localparam int ID_W     = calc_id_w(NUM_PORTS)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_PORTS-1:0]          req_valid_i,
  output logic [NUM_PORTS-1:0]          req_ready_o,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_PORTS-1:0]          req_we_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_PORTS*LEN_W-1:0]    req_len_i,
  output logic                          mem_valid_o,
  input  logic                          mem_ready_i,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_we_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic                          mem_last_o,
  output logic [NUM_PORTS-1:0]          grant_o,
  output logic [ID_W-1:0]               grant_id_o
);

  arb_state_e           state_reg, state_next;
  logic [NUM_PORTS-1:0] grant_reg, grant_next;
  logic [ID_W-1:0]      grant_id_reg, grant_id_next;
  logic [ID_W-1:0]      last_ptr_reg, last_ptr_next;
  logic [LEN_W-1:0]     beat_cnt_reg, beat_cnt_next;

  logic [NUM_PORTS-1:0] mask, masked_grant, plain_grant, winner;
  logic [ID_W-1:0]      winner_id;
  logic [LEN_W-1:0]     winner_len;
  logic                 beat_acc;

  // Ports above the last-served one get first pick this round
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
    assign mask[gi] = (ID_W'(gi) > last_ptr_reg);
  end

  priority_arbiter #(.N(NUM_PORTS)) u_arb_masked (
    .req   (req_valid_i & mask),
    .grant (masked_grant)
  );

  priority_arbiter #(.N(NUM_PORTS)) u_arb_plain (
    .req   (req_valid_i),
    .grant (plain_grant)
  );

  assign winner = (|masked_grant) ? masked_grant : plain_grant;

  always_comb begin
    winner_id  = '0;
    winner_len = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (winner[i]) begin
        winner_id  = winner_id | ID_W'(i);
        winner_len = winner_len | req_len_i[i*LEN_W +: LEN_W];
      end
    end
  end

  assign beat_acc = (state_reg == BUSY) & req_valid_i[grant_id_reg] & mem_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      beat_cnt_reg <= '0;
      last_ptr_reg <= ID_W'(NUM_PORTS - 1);
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      beat_cnt_reg <= beat_cnt_next;
      last_ptr_reg <= last_ptr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    beat_cnt_next = beat_cnt_reg;
    last_ptr_next = last_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|req_valid_i) begin
          state_next    = BUSY;
          grant_next    = winner;
          grant_id_next = winner_id;
          beat_cnt_next = winner_len;
        end
      end
      BUSY: begin
        if (beat_acc) begin
          if (beat_cnt_reg == '0) begin
            state_next    = IDLE;
            grant_next    = '0;
            grant_id_next = '0;
            last_ptr_next = grant_id_reg;
          end else begin
            beat_cnt_next = beat_cnt_reg - LEN_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_valid_o = 1'b0;
    req_ready_o = '0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_last_o  = 1'b0;
    if (state_reg == BUSY) begin
      mem_valid_o = req_valid_i[grant_id_reg];
      req_ready_o = grant_reg & {NUM_PORTS{mem_ready_i}};
      mem_addr_o  = req_addr_i[grant_id_reg*ADDR_W +: ADDR_W];
      mem_we_o    = req_we_i[grant_id_reg];
      mem_wdata_o = req_wdata_i[grant_id_reg*DATA_W +: DATA_W];
      mem_last_o  = (beat_cnt_reg == '0);
    end
  end

  assign grant_o    = grant_reg;
  assign grant_id_o = grant_id_reg;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed self-checking bench for rr_burst_arbiter with hand-computed expectations.
module tb_rr_burst_arbiter;

  localparam int NP = 16;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic             clk;
  logic             rst;
  logic [NP-1:0]    valid;
  logic [NP-1:0]    ready_o;
  logic [NP*AW-1:0] addr_bus;
  logic [NP-1:0]    we_bus;
  logic [NP*DW-1:0] wdata_bus;
  logic [NP*LW-1:0] len_bus;
  logic             mem_valid;
  logic             mem_ready;
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  logic [DW-1:0]    mem_wdata;
  logic             mem_last;
  logic [NP-1:0]    grant;
  logic [3:0]       grant_id;

  logic [LW-1:0]    len_arr [NP];

  int checks   = 0;
  int failures = 0;
  int accepts;

  rr_burst_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .LEN_W     (LW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (valid),
    .req_ready_o (ready_o),
    .req_addr_i  (addr_bus),
    .req_we_i    (we_bus),
    .req_wdata_i (wdata_bus),
    .req_len_i   (len_bus),
    .mem_valid_o (mem_valid),
    .mem_ready_i (mem_ready),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .mem_last_o  (mem_last),
    .grant_o     (grant),
    .grant_id_o  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each port presents a recognisable address/data; odd ports write
  always_comb begin
    addr_bus  = '0;
    wdata_bus = '0;
    we_bus    = '0;
    len_bus   = '0;
    for (int p = 0; p < NP; p++) begin
      addr_bus[p*AW +: AW]  = 32'hA000_0000 + 32'(p);
      wdata_bus[p*DW +: DW] = 32'hD000_0000 + 32'(p);
      we_bus[p]             = (p % 2) == 1;
      len_bus[p*LW +: LW]   = len_arr[p];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_grant"}, 64'(grant), 64'(0));
    check_eq({tag, "_id"}, 64'(grant_id), 64'(0));
    check_eq({tag, "_mvalid"}, 64'(mem_valid), 64'(0));
    check_eq({tag, "_ready"}, 64'(ready_o), 64'(0));
    check_eq({tag, "_last"}, 64'(mem_last), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    valid = '0;
    mem_ready = 1'b0;
    for (int p = 0; p < NP; p++) len_arr[p] = '0;

    repeat (2) @(posedge clk);
    #2;
    check_idle("reset");
    valid = '1;
    mem_ready = 1'b1;
    #1;
    check_idle("reset_req");
    valid = '0;
    rst = 1'b0;

    // Single requester, 3-beat burst; len change after grant must be ignored
    len_arr[3] = 4'd2;
    valid = 16'h0008;
    #1;
    check_eq("t1_pre_mvalid", 64'(mem_valid), 64'(0));
    step();
    len_arr[3] = 4'd0;
    #1;
    check_eq("t1_id", 64'(grant_id), 64'(3));
    check_eq("t1_grant", 64'(grant), 64'(16'h0008));
    check_eq("t1_mvalid", 64'(mem_valid), 64'(1));
    check_eq("t1_ready", 64'(ready_o), 64'(16'h0008));
    check_eq("t1_addr", 64'(mem_addr), 64'(32'hA000_0003));
    check_eq("t1_last0", 64'(mem_last), 64'(0));
    step();
    check_eq("t1_last1", 64'(mem_last), 64'(0));
    step();
    check_eq("t1_last2", 64'(mem_last), 64'(1));
    check_eq("t1_wdata", 64'(mem_wdata), 64'(32'hD000_0003));
    check_eq("t1_we", 64'(mem_we), 64'(1));
    step();
    valid = '0;
    #1;
    check_idle("t1_bubble");

    // All ports valid, single-beat bursts: strict rotation 0..15,0 every 2 cycles
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int p = 0; p < NP; p++) len_arr[p] = '0;
    valid = '1;
    mem_ready = 1'b1;
    step();
    for (int k = 0; k <= NP; k++) begin
      check_eq($sformatf("rr_id_%0d", k), 64'(grant_id), 64'(k % NP));
      check_eq($sformatf("rr_last_%0d", k), 64'(mem_last), 64'(1));
      step();
      check_eq($sformatf("rr_gap_%0d", k), 64'(grant), 64'(0));
      if (k == NP) valid = '0;
      step();
    end

    // Rotation past the last-served port: 5, then 2 wins over 5, then 5 again
    valid = 16'h0020;
    step();
    check_eq("t3_first5", 64'(grant_id), 64'(5));
    step();
    valid = 16'h0024;
    step();
    check_eq("t3_win2", 64'(grant_id), 64'(2));
    step();
    check_eq("t3_gap", 64'(grant), 64'(0));
    step();
    check_eq("t3_win5", 64'(grant_id), 64'(5));
    step();
    valid = '0;

    // Back-pressure on a 4-beat burst from port 9 while port 1 also waits
    len_arr[9] = 4'd3;
    len_arr[1] = 4'd0;
    valid = 16'h0202;
    step();
    check_eq("t4_id", 64'(grant_id), 64'(9));
    accepts = 0;
    for (int c = 0; c < 7; c++) begin
      mem_ready = (c % 2) == 0;
      #1;
      check_eq($sformatf("t4_ready_%0d", c), 64'(ready_o), mem_ready ? 64'(16'h0200) : 64'(0));
      check_eq($sformatf("t4_last_%0d", c), 64'(mem_last), 64'(accepts == 3));
      check_eq($sformatf("t4_hold_%0d", c), 64'(grant_id), 64'(9));
      step();
      if (mem_ready) accepts++;
    end
    check_eq("t4_gap", 64'(grant), 64'(0));
    mem_ready = 1'b1;
    step();
    check_eq("t4_next1", 64'(grant_id), 64'(1));
    step();
    valid = '0;

    // Granted port 4 stalls for 10 cycles while port 7 requests
    len_arr[4] = 4'd2;
    len_arr[7] = 4'd0;
    valid = 16'h0010;
    step();
    check_eq("t5_id", 64'(grant_id), 64'(4));
    step();
    valid = 16'h0080;
    for (int c = 0; c < 10; c++) begin
      #1;
      check_eq($sformatf("t5_stall_mv_%0d", c), 64'(mem_valid), 64'(0));
      check_eq($sformatf("t5_stall_g_%0d", c), 64'(grant), 64'(16'h0010));
      step();
    end
    valid = 16'h0090;
    #1;
    check_eq("t5_resume_mv", 64'(mem_valid), 64'(1));
    check_eq("t5_resume_last", 64'(mem_last), 64'(0));
    step();
    check_eq("t5_last", 64'(mem_last), 64'(1));
    check_eq("t5_last_id", 64'(grant_id), 64'(4));
    step();
    valid = 16'h0080;
    #1;
    check_eq("t5_gap", 64'(grant), 64'(0));
    step();
    check_eq("t5_win7", 64'(grant_id), 64'(7));
    step();
    valid = '0;

    // Reset mid-burst on beat 2 of a 6-beat burst
    len_arr[10] = 4'd5;
    valid = 16'h0400;
    step();
    check_eq("t6_id", 64'(grant_id), 64'(10));
    step();
    check_eq("t6_mvalid", 64'(mem_valid), 64'(1));
    rst = 1'b1;
    #1;
    check_idle("t6_rst");
    valid = 16'h0401;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check_eq("t6_after_id", 64'(grant_id), 64'(0));
    check_eq("t6_after_grant", 64'(grant), 64'(16'h0001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Round-robin arbiter that shares one downstream memory/bus port among NUM_PORTS requesters (compute-unit load/store queues) with per-port valid/ready handshakes. A grant, once issued, is locked for a whole burst of req_len+1 beats, so beats from different requesters never interleave. Fairness comes from a rotating priority pointer layered over the fixed-priority one-hot arbiter in util. It sits between the CU memory request queues and the shared L2/memory interface.

## Interface
- NUM_PORTS, 16, number of requesters (≥2)
- ADDR_W, 32, address width
- DATA_W, 32, write-data width
- LEN_W, 4, burst length field width; value = beats − 1
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  NUM_PORTS  per-port beat valid
- req_ready_o  out  NUM_PORTS  per-port beat accept
- req_addr_i  in  NUM_PORTS*ADDR_W  per-port beat address, port p at [p*ADDR_W +: ADDR_W]
- req_we_i  in  NUM_PORTS  per-port write enable
- req_wdata_i  in  NUM_PORTS*DATA_W  per-port write data
- req_len_i  in  NUM_PORTS*LEN_W  per-port burst length, sampled at grant only
- mem_valid_o  out  1  downstream beat valid
- mem_ready_i  in  1  downstream beat accept
- mem_addr_o / mem_we_o / mem_wdata_o  out  ADDR_W / 1 / DATA_W  muxed beat from granted port
- mem_last_o  out  1  final beat of the current burst
- grant_o  out  NUM_PORTS  registered one-hot owner (all zeros when idle)
- grant_id_o  out  $clog2(NUM_PORTS)  binary index of grant_o; 0 when idle

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if req_valid_i is nonzero, pick a winner; register grant_o/grant_id_o; load beat_cnt ← req_len_i[winner]; go to BUSY. If req_valid_i is zero, stay in IDLE.
- Winner selection: mask = ports with index > last_ptr. If req_valid_i & mask is nonzero, the lowest set bit of that wins. Otherwise the lowest set bit of req_valid_i wins.
- BUSY, granted port g:
  - mem_valid_o = req_valid_i[g]
  - req_ready_o[g] = mem_ready_i; all other ready bits are 0
  - mem_addr/we/wdata are muxed from port g
  - mem_last_o = (beat_cnt == 0)
- A beat is accepted when mem_valid_o & mem_ready_i:
  - beat_cnt ≠ 0: decrement beat_cnt
  - beat_cnt == 0: last_ptr ← g; clear the grant; go to IDLE
- The granted requester may drop valid mid-burst. The grant is held indefinitely and mem_valid_o stays 0. There is no timeout.
- req_len_i changes after grant are ignored.
- In IDLE: mem_valid_o = 0, req_ready_o = 0, mem_last_o = 0, and mem_addr/we/wdata = 0.
- The pointer advances only on burst completion. A port just served has lowest priority in the next arbitration.
- beat_cnt is LEN_W wide and never wraps: a decrement at 0 cannot occur.

## Timing
- Reset values: state = IDLE, grant_o = 0, grant_id_o = 0, beat_cnt = 0, last_ptr = NUM_PORTS−1 (port 0 wins first). All outputs are 0 during reset.
- Arbitration latency: a request visible in IDLE at edge N is granted after edge N. Its first beat can be accepted in the cycle after edge N.
- req_ready_o is combinational from mem_ready_i. There is no skid buffer and zero added beat latency.
- One IDLE bubble cycle follows every burst. Peak throughput is len+1 beats per len+2 cycles.
- Simultaneous new requests during BUSY are only considered at the next IDLE cycle.
- Reset asserted mid-burst: immediately return to the reset values. The downstream sees mem_valid_o drop asynchronously, and the partial burst is abandoned.

## Structure
- Package rtgpu_arb_pkg:
  - localparam function for ID_W = $clog2(NUM_PORTS)
  - typedef enum logic {IDLE, BUSY} arb_state_e
- Sub-module: two instances of priority_arbiter (NUM_PORTS), one on the masked request vector and one on the unmasked vector, plus a select.
- Everything else stays local: the one-hot-to-binary encoder, the data mux and the FSM.

## Test plan
- Single requester: port 3 valid, len = 2, mem_ready_i = 1 → grant_id_o = 3 one cycle later; three beats accepted; mem_last_o on the third; one IDLE cycle; grant_o = 0.
- All 16 ports continuously valid, len = 0 → grants in order 0, 1, 2 … 15, 0, with each grant separated by exactly 2 cycles.
- Ports 2 and 5 valid after port 5 finished (last_ptr = 5) → port 2 wins. After port 2 finishes, port 5 wins again.
- mem_ready_i toggles 1, 0, 1, 0 during a 4-beat burst → only accepted beats decrement the count; no other port's ready ever asserts; last_ptr updates only on the 4th accept.
- Granted port drops valid for 10 cycles mid-burst while port 7 requests → grant is held, mem_valid_o = 0, port 7 waits. The burst resumes and completes, then port 7 is granted.
- rst_i asserted on beat 2 of a len = 5 burst → all outputs are 0 immediately. After release, port 0 wins if valid.
